// File: rtl/stream_arb_mux.sv
// Packet-granular N:1 stream multiplexer: arbitrates between PORTS sources, holds the
// grant until the winning packet's tlast, and registers output through a 2-entry skid buffer.
module stream_arb_mux #(
    parameter int    PORTS        = 4,
    parameter int    DATA_WIDTH   = 8,
    parameter string ARB_TYPE     = "ROUND_ROBIN",
    parameter string LSB_PRIORITY = "LOW"
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [PORTS*DATA_WIDTH-1:0]   s_tdata,
    input  logic [PORTS-1:0]              s_tvalid,
    input  logic [PORTS-1:0]              s_tlast,
    output logic [PORTS-1:0]              s_tready,
    output logic [DATA_WIDTH-1:0]         m_tdata,
    output logic                          m_tvalid,
    output logic                          m_tlast,
    output logic [$clog2(PORTS)-1:0]      m_tid,
    input  logic                          m_tready
);

    localparam int IDW     = $clog2(PORTS);
    localparam bit IS_PRIO = (ARB_TYPE == "PRIORITY");
    localparam bit LSB_LOW = (LSB_PRIORITY == "LOW");

    // Handshake: a beat moves on any interface exactly in a cycle where valid and ready
    // are both high at the rising edge; valid never waits on ready.

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                state;
    logic [PORTS-1:0]      grant;
    logic [IDW-1:0]        grant_idx;
    logic [IDW-1:0]        rr_ptr;

    logic [IDW-1:0]        first_idx;
    logic [IDW-1:0]        after_idx;
    logic                  have_first;
    logic                  have_after;
    logic [IDW-1:0]        win_idx;

    logic [DATA_WIDTH-1:0] lane [PORTS];
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;
    logic                  accept;

    logic                  main_valid;
    logic [DATA_WIDTH-1:0] main_data;
    logic                  main_last;
    logic [IDW-1:0]        main_id;
    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  skid_last;
    logic [IDW-1:0]        skid_id;
    logic                  main_free;

    for (genvar gi = 0; gi < PORTS; gi++) begin : g_lane
        assign lane[gi] = s_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Scan requesters in priority order: the first one overall, and the first one that
    // lies strictly past the last grant (round-robin successor, falls back to the first).
    always_comb begin
        first_idx  = '0;
        after_idx  = '0;
        have_first = 1'b0;
        have_after = 1'b0;
        if (LSB_LOW) begin
            for (int i = 0; i < PORTS; i++) begin
                if (s_tvalid[i]) begin
                    if (!have_first) begin
                        have_first = 1'b1;
                        first_idx  = IDW'(i);
                    end
                    if (!have_after && (IDW'(i) > rr_ptr)) begin
                        have_after = 1'b1;
                        after_idx  = IDW'(i);
                    end
                end
            end
        end else begin
            for (int i = PORTS - 1; i >= 0; i--) begin
                if (s_tvalid[i]) begin
                    if (!have_first) begin
                        have_first = 1'b1;
                        first_idx  = IDW'(i);
                    end
                    if (!have_after && (IDW'(i) < rr_ptr)) begin
                        have_after = 1'b1;
                        after_idx  = IDW'(i);
                    end
                end
            end
        end
        win_idx = (!IS_PRIO && have_after) ? after_idx : first_idx;
    end

    // Ready depends only on registered state, never on m_tready.
    assign s_tready = (state == BUSY && !skid_valid) ? grant : '0;
    assign accept   = |(s_tready & s_tvalid);
    assign in_data  = lane[grant_idx];
    assign in_last  = s_tlast[grant_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            rr_ptr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (have_first) begin
                        grant     <= PORTS'(1) << win_idx;
                        grant_idx <= win_idx;
                        rr_ptr    <= win_idx;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (accept && in_last) begin
                        grant <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign main_free = !main_valid || m_tready;

    // Skid slot only fills when the main slot is held; it always drains into main first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_last  <= 1'b0;
            main_id    <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_last  <= 1'b0;
            skid_id    <= '0;
        end else if (main_free) begin
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_data  <= skid_data;
                main_last  <= skid_last;
                main_id    <= skid_id;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= accept;
                if (accept) begin
                    main_data <= in_data;
                    main_last <= in_last;
                    main_id   <= grant_idx;
                end
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
            skid_last  <= in_last;
            skid_id    <= grant_idx;
        end
    end

    assign m_tvalid = main_valid;
    assign m_tdata  = main_data;
    assign m_tlast  = main_last;
    assign m_tid    = main_id;

endmodule

// File: tb/tb_stream_arb_mux.sv
// Bench for stream_arb_mux: queue-based reference model checked every cycle, directed
// packet scenarios with literal expectations, and two PRIORITY-mode instances.
module tb_stream_arb_mux;

  localparam int PORTS = 4;
  localparam int DW    = 8;
  localparam int IW    = 2;
  localparam int OW    = IW + 1 + DW;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [PORTS*DW-1:0] s_tdata;
  logic [PORTS-1:0]    s_tvalid;
  logic [PORTS-1:0]    s_tlast;
  logic [PORTS-1:0]    s_tready;
  logic [DW-1:0]       m_tdata;
  logic                m_tvalid;
  logic                m_tlast;
  logic [IW-1:0]       m_tid;
  logic                m_tready;

  logic [PORTS*DW-1:0] p_tdata;
  logic [PORTS-1:0]    p_tvalid;
  logic [PORTS-1:0]    p_tlast;
  logic                p_ready;
  logic [PORTS-1:0]    pl_tready, ph_tready;
  logic [DW-1:0]       pl_tdata, ph_tdata;
  logic                pl_tvalid, ph_tvalid, pl_tlast, ph_tlast;
  logic [IW-1:0]       pl_tid, ph_tid;

  stream_arb_mux #(.PORTS(PORTS), .DATA_WIDTH(DW), .ARB_TYPE("ROUND_ROBIN"), .LSB_PRIORITY("LOW")) dut (
    .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tid(m_tid), .m_tready(m_tready));

  stream_arb_mux #(.PORTS(PORTS), .DATA_WIDTH(DW), .ARB_TYPE("PRIORITY"), .LSB_PRIORITY("LOW")) dut_pl (
    .clk(clk), .rst_n(rst_n), .s_tdata(p_tdata), .s_tvalid(p_tvalid), .s_tlast(p_tlast),
    .s_tready(pl_tready), .m_tdata(pl_tdata), .m_tvalid(pl_tvalid), .m_tlast(pl_tlast),
    .m_tid(pl_tid), .m_tready(p_ready));

  stream_arb_mux #(.PORTS(PORTS), .DATA_WIDTH(DW), .ARB_TYPE("PRIORITY"), .LSB_PRIORITY("HIGH")) dut_ph (
    .clk(clk), .rst_n(rst_n), .s_tdata(p_tdata), .s_tvalid(p_tvalid), .s_tlast(p_tlast),
    .s_tready(ph_tready), .m_tdata(ph_tdata), .m_tvalid(ph_tvalid), .m_tlast(ph_tlast),
    .m_tid(ph_tid), .m_tready(p_ready));

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got cycle limit expected completion");
    $fatal(1);
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // per-port source queues
  logic [DW-1:0] src_data [PORTS][DEPTH];
  logic          src_last [PORTS][DEPTH];
  int            src_gap  [PORTS][DEPTH];
  int            rd   [PORTS];
  int            wr   [PORTS];
  int            gapc [PORTS];
  logic [PORTS-1:0] hs_src;
  logic          rst_seen;
  logic          pt1, pt3, pl_hs, ph_hs;
  int            pl_pkts = 0;
  int            ph_pkts = 0;

  // reference model: arbitration state plus the beats currently held in the DUT
  logic            m_busy = 1'b0;
  int              m_win  = 0;
  int              m_ptr  = 0;
  logic [OW-1:0]   exp_q[$];

  int obs_data[$];
  int obs_tid[$];
  int obs_last[$];
  int obs_cyc[$];

  int rr_exp[5] = '{0, 1, 2, 3, 0};
  int bp_pat[16] = '{1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 1, 0, 1, 1, 1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Round-robin rule: first requester strictly after the last grant, wrapping.
  function automatic int rr_pick(input logic [PORTS-1:0] req, input int last);
    for (int k = 1; k <= PORTS; k++)
      if (req[(last + k) % PORTS]) return (last + k) % PORTS;
    return 0;
  endfunction

  // scoreboard / compare process body, run once per cycle on the falling edge
  task automatic model_cycle();
    logic [PORTS-1:0] exp_rdy;
    logic [OW-1:0]    hd;
    logic             hs, dr;
    exp_rdy = (m_busy && exp_q.size() < 2) ? (4'b0001 << m_win) : 4'b0000;
    check("s_tready", s_tready, exp_rdy);
    check("m_tvalid", m_tvalid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      hd = exp_q[0];
      check("m_tdata", m_tdata, hd[DW-1:0]);
      check("m_tlast", m_tlast, hd[DW]);
      check("m_tid", m_tid, hd[OW-1 -: IW]);
    end
    if (rst_n && m_tvalid && m_tready) begin
      obs_data.push_back(int'(m_tdata));
      obs_tid.push_back(int'(m_tid));
      obs_last.push_back(int'(m_tlast));
      obs_cyc.push_back(cyc);
    end
    hs_src   = rst_n ? (s_tvalid & s_tready) : '0;
    rst_seen = !rst_n;

    if (rst_n) begin
      check("pl_rdy_other", pl_tready & 4'b1101, 0);
      check("ph_rdy_other", ph_tready & 4'b0111, 0);
      if (pl_tvalid) begin
        check("pl_tid", pl_tid, 1);
        check("pl_tdata", pl_tdata, 8'h11);
        if (pl_tlast) pl_pkts++;
      end
      if (ph_tvalid) begin
        check("ph_tid", ph_tid, 3);
        check("ph_tdata", ph_tdata, 8'h33);
        if (ph_tlast) ph_pkts++;
      end
    end
    pl_hs = rst_n && pl_tready[1];
    ph_hs = rst_n && ph_tready[3];

    hs = m_busy && exp_q.size() < 2 && s_tvalid[m_win];
    dr = exp_q.size() > 0 && m_tready;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_win  = 0;
      m_ptr  = 0;
      exp_q.delete();
    end else begin
      if (dr) void'(exp_q.pop_front());
      if (hs) exp_q.push_back({m_win[IW-1:0], s_tlast[m_win], s_tdata[m_win*DW +: DW]});
      if (!m_busy) begin
        if (|s_tvalid) begin
          m_win  = rr_pick(s_tvalid, m_ptr);
          m_ptr  = m_win;
          m_busy = 1'b1;
        end
      end else if (hs && s_tlast[m_win]) begin
        m_busy = 1'b0;
      end
    end
  endtask

  // driver tasks
  task automatic refresh();
    for (int p = 0; p < PORTS; p++) begin
      if (rd[p] < wr[p] && gapc[p] == 0) begin
        s_tvalid[p]          = 1'b1;
        s_tdata[p*DW +: DW]  = src_data[p][rd[p]];
        s_tlast[p]           = src_last[p][rd[p]];
      end else begin
        s_tvalid[p]          = 1'b0;
        s_tdata[p*DW +: DW]  = '0;
        s_tlast[p]           = 1'b0;
      end
    end
    p_tlast[1] = pt1;
    p_tlast[3] = pt3;
  endtask

  task automatic drive_sources();
    for (int p = 0; p < PORTS; p++) begin
      if (hs_src[p]) begin
        rd[p]++;
        gapc[p] = (rd[p] < wr[p]) ? src_gap[p][rd[p]] : 0;
      end else if (rd[p] < wr[p] && gapc[p] > 0) begin
        gapc[p]--;
      end
    end
    if (rst_seen) begin
      pt1 = 1'b0;
      pt3 = 1'b0;
    end else begin
      if (pl_hs) pt1 = ~pt1;
      if (ph_hs) pt3 = ~pt3;
    end
    refresh();
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    cyc++;
    #1;
    drive_sources();
  endtask

  task automatic push(input int p, input logic [DW-1:0] d, input logic l, input int g);
    if (rd[p] == wr[p]) gapc[p] = g;
    src_data[p][wr[p]] = d;
    src_last[p][wr[p]] = l;
    src_gap[p][wr[p]]  = g;
    wr[p]++;
  endtask

  task automatic push_pkt(input int p, input logic [DW-1:0] base, input int len,
                          input int gap_at, input int gap_len);
    for (int i = 0; i < len; i++)
      push(p, base + DW'(i), i == len - 1, (i == gap_at) ? gap_len : 0);
  endtask

  function automatic logic all_empty();
    for (int p = 0; p < PORTS; p++)
      if (rd[p] != wr[p]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (!(all_empty() && exp_q.size() == 0 && !m_busy) && n < budget) begin
      step();
      n++;
    end
    check(name, n < budget, 1);
    step();
    step();
  endtask

  initial begin
    int start, np, prev_c, n, r3;
    logic first;
    s_tdata  = '0;
    s_tvalid = '0;
    s_tlast  = '0;
    m_tready = 1'b1;
    p_tdata  = {8'h33, 8'h22, 8'h11, 8'h00};
    p_tvalid = 4'b1010;
    p_tlast  = '0;
    p_ready  = 1'b1;
    pt1      = 1'b0;
    pt3      = 1'b0;
    rst_n    = 1'b0;

    // reset and single packet
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_m_tvalid", m_tvalid, 0);
      check("rst_m_tdata", m_tdata, 0);
      check("rst_m_tlast", m_tlast, 0);
      check("rst_m_tid", m_tid, 0);
      check("rst_s_tready", s_tready, 0);
      check("rst_state", dut.state, 0);
    end
    rst_n = 1'b1;
    push_pkt(2, 8'hA1, 3, -1, 0);
    refresh();
    step();
    check("t1_c1_s_tready", s_tready, 4'b0100);
    check("t1_c1_m_tvalid", m_tvalid, 0);
    for (int c = 2; c <= 4; c++) begin
      step();
      check("t1_m_tvalid", m_tvalid, 1);
      check("t1_m_tdata", m_tdata, 8'hA1 + c - 2);
      check("t1_m_tid", m_tid, 2);
      check("t1_m_tlast", m_tlast, c == 4);
    end
    wait_drain("t1_timeout", 20);

    // round-robin fairness: port 0 alone at the first decision, then all four contend
    start = obs_data.size();
    for (int k = 0; k < 3; k++) push_pkt(0, 8'h00 + DW'(k * 2), 2, -1, 0);
    refresh();
    step();
    for (int p = 1; p < PORTS; p++)
      for (int k = 0; k < 3; k++) push_pkt(p, DW'(p * 16 + k * 2), 2, -1, 0);
    refresh();
    wait_drain("rr_timeout", 300);
    np = 0;
    prev_c = 0;
    first = 1'b1;
    for (int j = start; j < obs_data.size(); j++) begin
      if (first) begin
        if (np < 5) check("rr_tid_order", obs_tid[j], rr_exp[np]);
        if (np > 0) check("rr_bubble_spacing", obs_cyc[j] - prev_c, 3);
        prev_c = obs_cyc[j];
        np++;
      end
      first = obs_last[j][0];
    end
    check("rr_packet_count", np, 12);

    // backpressure with a stall pattern on m_tready
    start = obs_data.size();
    push_pkt(0, 8'h10, 8, -1, 0);
    refresh();
    n = 0;
    while (!(all_empty() && exp_q.size() == 0 && !m_busy) && n < 200) begin
      m_tready = (bp_pat[n % 16] != 0);
      step();
      n++;
    end
    check("bp_timeout", n < 200, 1);
    m_tready = 1'b1;
    step();
    check("bp_beat_count", obs_data.size() - start, 8);
    for (int j = 0; j < 8 && start + j < obs_data.size(); j++) begin
      check("bp_data", obs_data[start + j], 8'h10 + j);
      check("bp_last", obs_last[start + j], j == 7);
    end

    // mid-packet input gap on port 1 while port 0 waits
    start = obs_data.size();
    push_pkt(1, 8'h40, 4, 2, 5);
    refresh();
    step();
    push_pkt(0, 8'h50, 2, -1, 0);
    refresh();
    wait_drain("gap_timeout", 60);
    check("gap_beat_count", obs_data.size() - start, 6);
    for (int j = 0; j < 6 && start + j < obs_data.size(); j++) begin
      check("gap_tid", obs_tid[start + j], (j < 4) ? 1 : 0);
      check("gap_data", obs_data[start + j], (j < 4) ? (8'h40 + j) : (8'h50 + j - 4));
    end

    // reset after beat 2 of a 4-beat packet
    r3 = rd[3];
    push_pkt(3, 8'h60, 4, -1, 0);
    refresh();
    n = 0;
    while (rd[3] < r3 + 2 && n < 50) begin
      step();
      n++;
    end
    check("rstmid_wait", n < 50, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int p = 0; p < PORTS; p++) begin
      rd[p]   = wr[p];
      gapc[p] = 0;
    end
    refresh();
    check("rstmid_m_tvalid", m_tvalid, 0);
    check("rstmid_s_tready", s_tready, 0);
    check("rstmid_state", dut.state, 0);
    start = obs_data.size();
    push_pkt(0, 8'h70, 2, -1, 0);
    push_pkt(3, 8'h73, 2, -1, 0);
    refresh();
    wait_drain("rstmid_timeout", 40);
    check("rstmid_beat_count", obs_data.size() - start, 4);
    for (int j = 0; j < 4 && start + j < obs_data.size(); j++) begin
      check("rstmid_tid", obs_tid[start + j], (j < 2) ? 3 : 0);
      check("rstmid_data", obs_data[start + j], (j < 2) ? (8'h73 + j) : (8'h70 + j - 2));
    end

    check("pl_progress", pl_pkts > 20, 1);
    check("ph_progress", ph_pkts > 20, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_arb_mux.md
Name: stream_arb_mux

Overview:
- Packet-granular N:1 stream multiplexer: collects packets from PORTS upstream sources and merges them onto one output stream.
- Contains its own grant stage and switches sources only at packet boundaries (tlast).
- Feeds shared downstream consumers (FIFO, MAC, DMA write port).
- Output is registered with a 2-entry skid buffer, so s_tready never depends combinationally on m_tready.

Parameters:
- PORTS, 4, number of input streams; legal range 2..16.
- DATA_WIDTH, 8, width of each tdata lane.
- ARB_TYPE, "ROUND_ROBIN", "ROUND_ROBIN" or "PRIORITY".
- LSB_PRIORITY, "LOW", "LOW" means index 0 has highest priority; "HIGH" means index PORTS-1 has highest priority.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- s_tdata  in  PORTS*DATA_WIDTH  input data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_tvalid  in  PORTS  per-port valid.
- s_tlast  in  PORTS  per-port end-of-packet.
- s_tready  out  PORTS  per-port ready; at most one bit high in any cycle.
- m_tdata  out  DATA_WIDTH  output data.
- m_tvalid  out  1  output valid.
- m_tlast  out  1  output end-of-packet.
- m_tid  out  $clog2(PORTS)  source port index of the current output beat.
- m_tready  in  1  downstream ready.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE; grant=0; grant_idx=0; s_tready=0; m_tvalid=0; m_tlast=0; m_tdata=0; m_tid=0.
  - Skid buffer cleared; round-robin pointer=0.
  - Reset mid-packet drops the in-flight packet with no flush; the first beat after reset is treated as a new packet.
- FSM states: IDLE, BUSY.
- IDLE:
  - If any s_tvalid is high, select a winner, register grant (one-hot) and grant_idx, then go to BUSY next cycle.
  - s_tready is 0 throughout IDLE.
- Selection:
  - PRIORITY: first set bit per LSB_PRIORITY.
  - ROUND_ROBIN: first requester strictly after the last granted index, in priority direction, wrapping around. If no requester exists after it, take the highest-priority requester overall.
  - Round-robin pointer updates only when a grant is issued.
- BUSY:
  - s_tready[grant_idx] = NOT skid_full; all other bits are 0.
  - A beat transfers when s_tvalid[grant_idx] & s_tready[grant_idx].
  - A transferred beat with s_tlast=1 returns the FSM to IDLE next cycle and clears grant.
  - The grant is held across any number of idle (tvalid=0) cycles mid-packet; there is no timeout.
- Bubble: exactly one IDLE cycle between consecutive packets, so maximum throughput is L/(L+1) beats/cycle for L-beat packets.
- Output stage:
  - Registered main slot plus a skid slot.
  - Accepted beat enters the main slot if it is empty or draining this cycle, otherwise the skid slot.
  - Ordering is strictly preserved.
  - m_tid carries the grant_idx captured with the beat.
- Latency:
  - s_tvalid asserted in IDLE at cycle 0 → s_tready high at cycle 1 → beat on m_* at cycle 2.
  - Steady state: 1 cycle from input handshake to m_tvalid.
- Backpressure:
  - m_tready=0: the first unmatched beat goes to the skid slot; s_tready then drops the cycle after.
  - No beat is lost or duplicated.
  - m_tdata, m_tlast and m_tid are stable while m_tvalid=1 and m_tready=0.
- Ungranted ports: their s_tvalid and s_tlast are ignored; they keep requesting until granted.
- Single-beat packets (tlast on the first beat) are legal.
- Simultaneous events:
  - Output drain and new input accept in the same cycle are both performed.
  - tlast accept and new requests in the same cycle: arbitration waits for the IDLE cycle, and the current grant holder is eligible again only per the ROUND_ROBIN rule.
- Input rule: s_tvalid deasserting without a handshake is permitted and has no effect.

Test Plan:
- Reset and single packet:
  - Stimulus: rst_n low 3 cycles; port 2 sends 3 beats 0xA1,0xA2,0xA3 (tlast on 0xA3); m_tready=1.
  - Required: all outputs 0 during reset; m_tdata 0xA1..0xA3 on cycles 2..4, m_tid=2, m_tlast only on 0xA3.
- Round-robin fairness:
  - Stimulus: all 4 ports continuously send 2-beat packets tagged with the port number; ROUND_ROBIN, LSB "LOW".
  - Required: m_tid sequence 0,1,2,3,0,1,… per packet; one bubble cycle between packets.
- Priority mode:
  - Stimulus: ports 1 and 3 continuously request; ARB_TYPE="PRIORITY".
  - Required: LSB "LOW" always grants 1; LSB "HIGH" always grants 3; port 3 is never interleaved mid-packet.
- Backpressure:
  - Stimulus: port 0 sends 8-beat packet 0x10..0x17; m_tready toggles 1,0,0,1,1,0,… randomly.
  - Required: output is exactly 0x10..0x17 in order; outputs stay stable while stalled; s_tready falls within 1 cycle of skid_full.
- Mid-packet input gaps:
  - Stimulus: port 1 drops tvalid for 5 cycles mid-packet while port 0 requests.
  - Required: grant stays on port 1; port 0 is served only after port 1's tlast.
- Reset mid-packet:
  - Stimulus: rst_n low for 1 cycle after beat 2 of a 4-beat packet.
  - Required: next cycle m_tvalid=0 and state=IDLE; the following packet from any port arbitrates normally with pointer=0.
